csr_file_timer: RTL and testbench

- Next-generation LoongArch CSR file for the 5-stage CPU. Adds ECFG, BADV, TID, TCFG, TVAL and TICLR to the existing CRMD/PRMD/ESTAT/ERA/EENTRY/SAVE set.
- Adds a parametrised count-down timer, hardware/IPI interrupt sampling and interrupt-pending generation.
- Handles exception entry and ertn return from WB.
- Feeds has_int to ID for interrupt tagging, and ex_entry/ertn_pc to IF for redirect.

---
 rtl/csr_defs.sv | 51 +++++
 rtl/csr_timer.sv | 57 +++++
 rtl/csr_file_timer.sv | 156 +++++++++++++++
 tb/tb_csr_file_timer.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/csr_defs.sv
// rtl/csr_defs.sv - shared CSR addresses, field masks, ecodes and timer states
// Masks mark the software-writable bits of each CSR word.
package csr_defs;

  localparam logic [13:0] CSR_CRMD   = 14'h000;
  localparam logic [13:0] CSR_PRMD   = 14'h001;
  localparam logic [13:0] CSR_ECFG   = 14'h004;
  localparam logic [13:0] CSR_ESTAT  = 14'h005;
  localparam logic [13:0] CSR_ERA    = 14'h006;
  localparam logic [13:0] CSR_BADV   = 14'h007;
  localparam logic [13:0] CSR_EENTRY = 14'h00C;
  localparam logic [13:0] CSR_SAVE0  = 14'h030;
  localparam logic [13:0] CSR_TID    = 14'h040;
  localparam logic [13:0] CSR_TCFG   = 14'h041;
  localparam logic [13:0] CSR_TVAL   = 14'h042;
  localparam logic [13:0] CSR_TICLR  = 14'h044;

  localparam int CRMD_PLV_LSB = 0;
  localparam int CRMD_PLV_W   = 2;
  localparam int CRMD_IE_BIT  = 2;
  localparam int CRMD_DA_BIT  = 3;
  localparam int ESTAT_IS_W   = 13;
  localparam int ESTAT_ECODE_LSB = 16;
  localparam int ESTAT_ESUB_LSB  = 22;
  localparam int IS_TI_BIT    = 11;
  localparam int IS_IPI_BIT   = 12;

  localparam logic [31:0] CRMD_MASK   = 32'h0000_000F;
  localparam logic [31:0] PRMD_MASK   = 32'h0000_0007;
  localparam logic [31:0] ECFG_MASK   = 32'h0000_1BFF;
  localparam logic [31:0] ESTAT_SW_MASK = 32'h0000_0003;
  localparam logic [31:0] EENTRY_MASK = 32'hFFFF_FFC0;
  localparam logic [31:0] CRMD_RST    = 32'h0000_0008;

  localparam logic [5:0] ECODE_INT  = 6'h00;
  localparam logic [5:0] ECODE_ADEF = 6'h08;
  localparam logic [5:0] ECODE_ALE  = 6'h09;
  localparam logic [5:0] ECODE_SYS  = 6'h0B;
  localparam logic [5:0] ECODE_BRK  = 6'h0C;
  localparam logic [5:0] ECODE_INE  = 6'h0D;

  typedef enum logic {TMR_IDLE, TMR_RUN} timer_state_e;

  function automatic logic [31:0] csr_mwrite(input logic [31:0] old, input logic [31:0] we,
                                             input logic [31:0] wdata, input logic [31:0] mask);
    logic [31:0] m;
    m = we & mask;
    return (old & ~m) | (wdata & m);
  endfunction

endpackage

// File: rtl/csr_timer.sv
// rtl/csr_timer.sv - count-down timer with periodic reload and TI-set pulse
// tcfg_i is the effective TCFG this cycle (written value when tcfg_wr_i, else current).
module csr_timer
  import csr_defs::*;
#(
  parameter int TIMER_W = 32
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               tcfg_wr_i,
  input  logic [TIMER_W-1:0] tcfg_i,
  output logic [TIMER_W-1:0] tval_o,
  output logic               ti_set_o
);

  timer_state_e       state_q, state_d;
  logic [TIMER_W-1:0] tval_q, tval_d;
  logic [TIMER_W-1:0] reload;

  assign reload = {tcfg_i[TIMER_W-1:2], 2'b00};
  assign tval_o = tval_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= TMR_IDLE;
      tval_q  <= '1;
    end else begin
      state_q <= state_d;
      tval_q  <= tval_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    tval_d   = tval_q;
    ti_set_o = (state_q == TMR_RUN) && (tval_q == '0);
    // A TCFG write takes precedence over countdown and reload.
    if (tcfg_wr_i) begin
      if (tcfg_i[0]) begin
        tval_d  = reload;
        state_d = TMR_RUN;
      end else begin
        state_d = TMR_IDLE;
      end
    end else if (state_q == TMR_RUN) begin
      if (tval_q != '0) begin
        tval_d = tval_q - 1'b1;
      end else if (tcfg_i[1]) begin
        tval_d = reload;
      end else begin
        tval_d  = '1;
        state_d = TMR_IDLE;
      end
    end
  end

endmodule

// File: rtl/csr_file_timer.sv
// rtl/csr_file_timer.sv - LoongArch CSR file with timer, interrupt sampling and exception/ertn handling
// Exception and ertn commit from WB take priority over software writes to the mode registers.
module csr_file_timer
  import csr_defs::*;
#(
  parameter int          SAVE_NUM  = 4,
  parameter int          TIMER_W   = 32,
  parameter int          HWI_NUM   = 8,
  parameter logic [31:0] TID_RESET = 32'h0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [13:0]        raddr,
  output logic [31:0]        rdata,
  input  logic [31:0]        we,
  input  logic [13:0]        waddr,
  input  logic [31:0]        wdata,
  input  logic [HWI_NUM-1:0] hw_int_in,
  input  logic               ipi_int_in,
  input  logic               wb_ex,
  input  logic [5:0]         wb_ecode,
  input  logic [8:0]         wb_esubcode,
  input  logic [31:0]        wb_pc,
  input  logic               wb_va_err,
  input  logic [31:0]        wb_vaddr,
  input  logic               ertn,
  output logic               has_int,
  output logic [31:0]        ex_entry,
  output logic [31:0]        ertn_pc
);

  localparam logic [31:0] TCFG_MASK = 32'((64'd1 << TIMER_W) - 64'd1);

  logic [31:0] crmd_q, crmd_d, prmd_q, prmd_d, ecfg_q, ecfg_d;
  logic [31:0] era_q, era_d, badv_q, badv_d, eentry_q, eentry_d;
  logic [31:0] tid_q, tid_d, tcfg_q, tcfg_d;
  logic [ESTAT_IS_W-1:0] is_q, is_d;
  logic [5:0]  ecode_q, ecode_d;
  logic [8:0]  esub_q, esub_d;
  logic [31:0] save_q [SAVE_NUM];
  logic [31:0] estat_w;
  logic [7:0]  hw_ext;
  logic [TIMER_W-1:0] tval;
  logic        wr, ti_set;

  assign wr = |we;

  csr_timer #(.TIMER_W(TIMER_W)) u_timer (
    .clk_i     (clk),
    .rst_i     (rst),
    .tcfg_wr_i (wr && (waddr == CSR_TCFG)),
    .tcfg_i    (tcfg_d[TIMER_W-1:0]),
    .tval_o    (tval),
    .ti_set_o  (ti_set)
  );

  always_comb begin
    hw_ext = '0;
    hw_ext[HWI_NUM-1:0] = hw_int_in;
  end

  always_comb begin
    crmd_d   = crmd_q;
    prmd_d   = prmd_q;
    era_d    = era_q;
    badv_d   = badv_q;
    ecode_d  = ecode_q;
    esub_d   = esub_q;
    ecfg_d   = (wr && waddr == CSR_ECFG)   ? csr_mwrite(ecfg_q, we, wdata, ECFG_MASK)     : ecfg_q;
    eentry_d = (wr && waddr == CSR_EENTRY) ? csr_mwrite(eentry_q, we, wdata, EENTRY_MASK) : eentry_q;
    tid_d    = (wr && waddr == CSR_TID)    ? csr_mwrite(tid_q, we, wdata, 32'hFFFF_FFFF)  : tid_q;
    tcfg_d   = (wr && waddr == CSR_TCFG)   ? csr_mwrite(tcfg_q, we, wdata, TCFG_MASK)     : tcfg_q;
    if (wb_ex) begin
      prmd_d  = {29'b0, crmd_q[CRMD_IE_BIT:CRMD_PLV_LSB]};
      crmd_d  = crmd_q & ~32'h7;
      ecode_d = wb_ecode;
      esub_d  = wb_esubcode;
      era_d   = wb_pc;
      if (wb_va_err) badv_d = wb_vaddr;
    end else if (ertn) begin
      crmd_d = {crmd_q[31:3], prmd_q[2:0]};
    end else if (wr) begin
      if (waddr == CSR_CRMD) crmd_d = csr_mwrite(crmd_q, we, wdata, CRMD_MASK);
      if (waddr == CSR_PRMD) prmd_d = csr_mwrite(prmd_q, we, wdata, PRMD_MASK);
      if (waddr == CSR_ERA)  era_d  = csr_mwrite(era_q, we, wdata, 32'hFFFF_FFFF);
      if (waddr == CSR_BADV) badv_d = csr_mwrite(badv_q, we, wdata, 32'hFFFF_FFFF);
    end
    estat_w = csr_mwrite({19'b0, is_q}, we, wdata, ESTAT_SW_MASK);
    is_d = is_q;
    if (wr && waddr == CSR_ESTAT) is_d[1:0] = estat_w[1:0];
    is_d[9:2]  = hw_ext;
    is_d[10]   = 1'b0;
    // Timer expiry beats a same-cycle TICLR clear.
    if (ti_set)
      is_d[IS_TI_BIT] = 1'b1;
    else if (wr && waddr == CSR_TICLR && we[0] && wdata[0])
      is_d[IS_TI_BIT] = 1'b0;
    is_d[IS_IPI_BIT] = ipi_int_in;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      crmd_q   <= CRMD_RST;
      prmd_q   <= '0;
      ecfg_q   <= '0;
      era_q    <= '0;
      badv_q   <= '0;
      eentry_q <= '0;
      tid_q    <= TID_RESET;
      tcfg_q   <= '0;
      is_q     <= '0;
      ecode_q  <= '0;
      esub_q   <= '0;
      for (int i = 0; i < SAVE_NUM; i++) save_q[i] <= '0;
    end else begin
      crmd_q   <= crmd_d;
      prmd_q   <= prmd_d;
      ecfg_q   <= ecfg_d;
      era_q    <= era_d;
      badv_q   <= badv_d;
      eentry_q <= eentry_d;
      tid_q    <= tid_d;
      tcfg_q   <= tcfg_d;
      is_q     <= is_d;
      ecode_q  <= ecode_d;
      esub_q   <= esub_d;
      for (int i = 0; i < SAVE_NUM; i++)
        if (wr && waddr == CSR_SAVE0 + 14'(i))
          save_q[i] <= csr_mwrite(save_q[i], we, wdata, 32'hFFFF_FFFF);
    end
  end

  always_comb begin
    rdata = '0;
    case (raddr)
      CSR_CRMD:   rdata = crmd_q;
      CSR_PRMD:   rdata = prmd_q;
      CSR_ECFG:   rdata = ecfg_q;
      CSR_ESTAT:  rdata = {1'b0, esub_q, ecode_q, 3'b0, is_q};
      CSR_ERA:    rdata = era_q;
      CSR_BADV:   rdata = badv_q;
      CSR_EENTRY: rdata = eentry_q;
      CSR_TID:    rdata = tid_q;
      CSR_TCFG:   rdata = tcfg_q;
      CSR_TVAL:   rdata = 32'(tval);
      default:    rdata = '0;
    endcase
    for (int i = 0; i < SAVE_NUM; i++)
      if (raddr == CSR_SAVE0 + 14'(i)) rdata = save_q[i];
  end

  assign has_int  = crmd_q[CRMD_IE_BIT] & |(is_q & ecfg_q[ESTAT_IS_W-1:0]);
  assign ex_entry = {eentry_q[31:6], 6'b0};
  assign ertn_pc  = era_q;

endmodule

// File: tb/tb_csr_file_timer.sv
// tb/tb_csr_file_timer.sv - directed self-checking bench for csr_file_timer
`timescale 1ns/1ps
module tb_csr_file_timer;

  logic        clk = 1'b0;
  logic        rst;
  logic [13:0] raddr, waddr;
  logic [31:0] rdata, we, wdata, wb_pc, wb_vaddr, ex_entry, ertn_pc;
  logic [7:0]  hw_int_in;
  logic        ipi_int_in, wb_ex, wb_va_err, ertn, has_int;
  logic [5:0]  wb_ecode;
  logic [8:0]  wb_esubcode;
  int checks = 0;
  int errors = 0;

  always #10 clk = ~clk;

  csr_file_timer #(.SAVE_NUM(4), .TIMER_W(32), .HWI_NUM(8), .TID_RESET(32'h0)) dut (
    .clk(clk), .rst(rst), .raddr(raddr), .rdata(rdata), .we(we), .waddr(waddr),
    .wdata(wdata), .hw_int_in(hw_int_in), .ipi_int_in(ipi_int_in), .wb_ex(wb_ex),
    .wb_ecode(wb_ecode), .wb_esubcode(wb_esubcode), .wb_pc(wb_pc), .wb_va_err(wb_va_err),
    .wb_vaddr(wb_vaddr), .ertn(ertn), .has_int(has_int), .ex_entry(ex_entry), .ertn_pc(ertn_pc)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [13:0] a, output logic [31:0] d);
    raddr = a;
    #1;
    d = rdata;
  endtask

  task automatic csr_wr(input logic [13:0] a, input logic [31:0] d, input logic [31:0] m);
    waddr = a; wdata = d; we = m;
    tick();
    we = '0;
  endtask

  task automatic test_reset();
    logic [31:0] v;
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    rd(14'h000, v); checks++;
    if (v !== 32'h8) begin errors++; $display("FAIL reset_crmd got=%h exp=%h", v, 32'h8); end
    rd(14'h042, v); checks++;
    if (v !== 32'hFFFFFFFF) begin errors++; $display("FAIL reset_tval got=%h exp=%h", v, 32'hFFFFFFFF); end
    rd(14'h040, v); checks++;
    if (v !== 32'h0) begin errors++; $display("FAIL reset_tid got=%h exp=%h", v, 32'h0); end
    checks++;
    if ({has_int, ex_entry, ertn_pc} !== 65'h0) begin
      errors++; $display("FAIL reset_outs got=%b/%h/%h exp=0/0/0", has_int, ex_entry, ertn_pc);
    end
  endtask

  task automatic test_exception();
    logic [31:0] v;
    csr_wr(14'h000, 32'h7, 32'h7);
    wb_ex = 1'b1; wb_ecode = 6'hB; wb_esubcode = 9'h0; wb_pc = 32'h1c000100;
    tick();
    wb_ex = 1'b0;
    rd(14'h001, v); checks++;
    if (v !== 32'h7) begin errors++; $display("FAIL ex_prmd got=%h exp=%h", v, 32'h7); end
    rd(14'h000, v); checks++;
    if (v[2:0] !== 3'h0) begin errors++; $display("FAIL ex_crmd got=%h exp=%h", v[2:0], 3'h0); end
    rd(14'h005, v); checks++;
    if (v[21:16] !== 6'hB) begin errors++; $display("FAIL ex_ecode got=%h exp=%h", v[21:16], 6'hB); end
    checks++;
    if (ertn_pc !== 32'h1c000100) begin errors++; $display("FAIL ex_era got=%h exp=%h", ertn_pc, 32'h1c000100); end
    ertn = 1'b1;
    tick();
    ertn = 1'b0;
    rd(14'h000, v); checks++;
    if (v[2:0] !== 3'h7) begin errors++; $display("FAIL ertn_crmd got=%h exp=%h", v[2:0], 3'h7); end
  endtask

  task automatic test_timer_periodic();
    logic [31:0] v;
    csr_wr(14'h004, 32'h800, 32'hFFFFFFFF);
    csr_wr(14'h041, 32'hB, 32'hFFFFFFFF);
    rd(14'h042, v); checks++;
    if (v !== 32'd8) begin errors++; $display("FAIL per_load got=%0d exp=8", v); end
    for (int k = 7; k >= 0; k--) begin
      tick();
      rd(14'h042, v); checks++;
      if (v !== 32'(k) || has_int !== 1'b0) begin
        errors++; $display("FAIL per_count got=%0d/%b exp=%0d/0", v, has_int, k);
      end
    end
    tick();
    rd(14'h042, v); checks++;
    if (v !== 32'd8) begin errors++; $display("FAIL per_reload got=%0d exp=8", v); end
    rd(14'h005, v); checks++;
    if (v[11] !== 1'b1 || has_int !== 1'b1) begin
      errors++; $display("FAIL per_ti got=%b/%b exp=1/1", v[11], has_int);
    end
    csr_wr(14'h044, 32'h1, 32'h1);
    rd(14'h005, v); checks++;
    if (v[11] !== 1'b0 || has_int !== 1'b0) begin
      errors++; $display("FAIL ticlr got=%b/%b exp=0/0", v[11], has_int);
    end
    for (int k = 0; k < 7; k++) tick();
    rd(14'h005, v); checks++;
    if (v[11] !== 1'b0) begin errors++; $display("FAIL per_hold got=%b exp=0", v[11]); end
    tick();
    rd(14'h005, v); checks++;
    if (v[11] !== 1'b1) begin errors++; $display("FAIL per_ti2 got=%b exp=1", v[11]); end
    csr_wr(14'h041, 32'h0, 32'hFFFFFFFF);
    rd(14'h042, v);
    tick(); tick();
    begin
      logic [31:0] v2;
      rd(14'h042, v2); checks++;
      if (v2 !== v) begin errors++; $display("FAIL idle_hold got=%h exp=%h", v2, v); end
    end
  endtask

  task automatic test_timer_oneshot();
    logic [31:0] v;
    csr_wr(14'h044, 32'h1, 32'h1);
    csr_wr(14'h041, 32'h9, 32'hFFFFFFFF);
    for (int k = 0; k < 8; k++) tick();
    rd(14'h042, v); checks++;
    if (v !== 32'd0) begin errors++; $display("FAIL os_zero got=%0d exp=0", v); end
    tick();
    rd(14'h042, v); checks++;
    if (v !== 32'hFFFFFFFF || has_int !== 1'b1) begin
      errors++; $display("FAIL os_expire got=%h/%b exp=ffffffff/1", v, has_int);
    end
    csr_wr(14'h044, 32'h1, 32'h1);
    for (int k = 0; k < 12; k++) tick();
    rd(14'h042, v); checks++;
    if (v !== 32'hFFFFFFFF) begin errors++; $display("FAIL os_hold got=%h exp=ffffffff", v); end
    rd(14'h005, v); checks++;
    if (v[11] !== 1'b0) begin errors++; $display("FAIL os_once got=%b exp=0", v[11]); end
  endtask

  task automatic test_estat_mask();
    logic [31:0] v;
    csr_wr(14'h004, 32'h0, 32'hFFFFFFFF);
    csr_wr(14'h005, 32'hFFFFFFFF, 32'hFFFFFFFF);
    rd(14'h005, v); checks++;
    if (v !== 32'h000B0003) begin errors++; $display("FAIL estat_mask got=%h exp=%h", v, 32'h000B0003); end
    checks++;
    if (has_int !== 1'b0) begin errors++; $display("FAIL estat_nolie got=%b exp=0", has_int); end
    csr_wr(14'h004, 32'hFFFFFFFF, 32'hFFFFFFFF);
    rd(14'h004, v); checks++;
    if (v !== 32'h1BFF) begin errors++; $display("FAIL ecfg_mask got=%h exp=%h", v, 32'h1BFF); end
    csr_wr(14'h004, 32'h1, 32'hFFFFFFFF);
    checks++;
    if (has_int !== 1'b1) begin errors++; $display("FAIL swi_int got=%b exp=1", has_int); end
    csr_wr(14'h005, 32'h0, 32'h3);
    checks++;
    if (has_int !== 1'b0) begin errors++; $display("FAIL swi_clr got=%b exp=0", has_int); end
  endtask

  task automatic test_hwint_badv();
    logic [31:0] v;
    csr_wr(14'h004, 32'h4, 32'hFFFFFFFF);
    hw_int_in = 8'h01;
    #1; checks++;
    if (has_int !== 1'b0) begin errors++; $display("FAIL hwi_early got=%b exp=0", has_int); end
    tick(); checks++;
    if (has_int !== 1'b1) begin errors++; $display("FAIL hwi_rise got=%b exp=1", has_int); end
    hw_int_in = 8'h00;
    #1; checks++;
    if (has_int !== 1'b1) begin errors++; $display("FAIL hwi_hold got=%b exp=1", has_int); end
    tick(); checks++;
    if (has_int !== 1'b0) begin errors++; $display("FAIL hwi_fall got=%b exp=0", has_int); end
    wb_ex = 1'b1; wb_ecode = 6'h8; wb_va_err = 1'b1; wb_vaddr = 32'h1234; wb_pc = 32'h1c000200;
    tick();
    wb_va_err = 1'b0; wb_vaddr = 32'hDEAD;
    tick();
    wb_ex = 1'b0;
    rd(14'h007, v); checks++;
    if (v !== 32'h1234) begin errors++; $display("FAIL badv got=%h exp=%h", v, 32'h1234); end
    // wb_ex beats a same-cycle software ERA write
    waddr = 14'h006; wdata = 32'h55; we = 32'hFFFFFFFF; wb_ex = 1'b1; wb_pc = 32'h1c000300;
    tick();
    wb_ex = 1'b0; we = '0;
    checks++;
    if (ertn_pc !== 32'h1c000300) begin errors++; $display("FAIL era_prio got=%h exp=%h", ertn_pc, 32'h1c000300); end
  endtask

  task automatic test_misc_regs();
    logic [31:0] v;
    for (int i = 0; i < 5; i++) csr_wr(14'h030 + 14'(i), 32'hA0 + 32'(i), 32'hFFFFFFFF);
    for (int i = 0; i < 5; i++) begin
      rd(14'h030 + 14'(i), v); checks++;
      if (v !== ((i < 4) ? 32'hA0 + 32'(i) : 32'h0)) begin
        errors++; $display("FAIL save%0d got=%h exp=%h", i, v, (i < 4) ? 32'hA0 + 32'(i) : 32'h0);
      end
    end
    csr_wr(14'h00C, 32'hFFFFFFFF, 32'hFFFFFFFF);
    rd(14'h00C, v); checks++;
    if (v !== 32'hFFFFFFC0 || ex_entry !== 32'hFFFFFFC0) begin
      errors++; $display("FAIL eentry got=%h/%h exp=ffffffc0", v, ex_entry);
    end
    csr_wr(14'h040, 32'h12345678, 32'hFFFFFFFF);
    csr_wr(14'h040, 32'hAAAAAAAA, 32'h0000FFFF);
    rd(14'h040, v); checks++;
    if (v !== 32'h1234AAAA) begin errors++; $display("FAIL tid_mask got=%h exp=%h", v, 32'h1234AAAA); end
    csr_wr(14'h042, 32'h5, 32'hFFFFFFFF);
    rd(14'h042, v); checks++;
    if (v !== 32'hFFFFFFFF) begin errors++; $display("FAIL tval_ro got=%h exp=ffffffff", v); end
    rd(14'h044, v); checks++;
    if (v !== 32'h0) begin errors++; $display("FAIL ticlr_rd got=%h exp=0", v); end
    waddr = 14'h006; wdata = 32'h1c000400; we = 32'hFFFFFFFF;
    #1; checks++;
    if (ertn_pc !== 32'h1c000300) begin errors++; $display("FAIL era_early got=%h exp=%h", ertn_pc, 32'h1c000300); end
    tick();
    we = '0; checks++;
    if (ertn_pc !== 32'h1c000400) begin errors++; $display("FAIL era_wr got=%h exp=%h", ertn_pc, 32'h1c000400); end
  endtask

  task automatic test_reset_midcount();
    logic [31:0] v;
    csr_wr(14'h041, 32'h41, 32'hFFFFFFFF);
    tick(); tick(); tick();
    rd(14'h042, v); checks++;
    if (v !== 32'h3D) begin errors++; $display("FAIL mid_count got=%h exp=%h", v, 32'h3D); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick(); tick();
    rd(14'h042, v); checks++;
    if (v !== 32'hFFFFFFFF) begin errors++; $display("FAIL mid_reset got=%h exp=ffffffff", v); end
  endtask

  initial begin
    rst = 1'b1; raddr = '0; waddr = '0; we = '0; wdata = '0;
    hw_int_in = '0; ipi_int_in = 1'b0; wb_ex = 1'b0; wb_ecode = '0; wb_esubcode = '0;
    wb_pc = '0; wb_va_err = 1'b0; wb_vaddr = '0; ertn = 1'b0;
    test_reset();
    test_exception();
    test_timer_periodic();
    test_timer_oneshot();
    test_estat_mask();
    test_hwint_badv();
    test_misc_regs();
    test_reset_midcount();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
